// File: rtl/text_buf_pkg.sv
// Shared types and constants for the on-screen text buffer controller.
//   state_e    : controller FSM states
//   CH_*       : writer control codes
//   TXT_COLS/TXT_ROWS : screen geometry in character cells
package text_buf_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BSWR  = 2'd2
  } state_e;

  localparam logic [7:0] CH_BS        = 8'h08;
  localparam logic [7:0] CH_LF        = 8'h0A;
  localparam logic [7:0] CH_FF        = 8'h0C;
  localparam logic [7:0] CH_CR        = 8'h0D;
  localparam logic [7:0] CH_PRINT_MIN = 8'h20;

  localparam int unsigned TXT_COLS = 16;
  localparam int unsigned TXT_ROWS = 16;

endpackage

// File: rtl/text_ram.sv
// Single-port character RAM with synchronous read.
//   clk, rst_n : clock, async active-low reset (read register only)
//   en, we     : port enable, write enable (write when en && we)
//   addr       : cell address
//   wdata      : write data
//   rdata      : read data, updated the cycle after an en && !we access,
//                held otherwise; contents are not reset
module text_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  // Read register only changes on a read access, so it holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (en && we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/text_buf_ctrl.sv
// Text buffer controller: arbitrates one RAM port between the display read
// path (absolute priority, 1-cycle latency) and a character-stream writer
// with cursor handling, control codes and a clear-screen sequencer.
//   disp_req/disp_addr -> disp_code : renderer read, {col,row} addressing
//   wr_valid/wr_char/wr_ready       : writer handshake (wr_ready is comb.)
//   cursor_x/cursor_y               : current write cell
//   busy                            : clear sequence running
module text_buf_ctrl
  import text_buf_pkg::*;
#(
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  parameter int unsigned COL_W     = $clog2(TXT_COLS),
  parameter int unsigned ROW_W     = $clog2(TXT_ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   disp_req,
  input  logic [COL_W+ROW_W-1:0] disp_addr,
  output logic [7:0]             disp_code,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_char,
  output logic                   wr_ready,
  output logic [COL_W-1:0]       cursor_x,
  output logic [ROW_W-1:0]       cursor_y,
  output logic                   busy
);

  localparam int unsigned AW = COL_W + ROW_W;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [COL_W-1:0] cur_x_q, cur_x_d;
  logic [ROW_W-1:0] cur_y_q, cur_y_d;
  logic             busy_q, busy_d;

  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [7:0]       ram_wdata;

  // Next state, cursor update and RAM port mux. Display owns the port
  // whenever disp_req is high; every write path waits for disp_req low.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    ram_we    = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = FILL_CHAR;
    wr_ready  = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (!disp_req) begin
          ram_we    = 1'b1;
          ram_addr  = clr_cnt_q;
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (clr_cnt_q == '1) begin
            state_d = ST_IDLE;
            cur_x_d = '0;
            cur_y_d = '0;
          end
        end
      end

      ST_IDLE: begin
        wr_ready = !disp_req;
        if (wr_valid && !disp_req) begin
          if (wr_char >= CH_PRINT_MIN) begin
            ram_we    = 1'b1;
            ram_addr  = {cur_x_q, cur_y_q};
            ram_wdata = wr_char;
            cur_x_d   = cur_x_q + COL_W'(1);
            if (cur_x_q == '1) cur_y_d = cur_y_q + ROW_W'(1);
          end else begin
            case (wr_char)
              CH_LF: begin
                cur_x_d = '0;
                cur_y_d = cur_y_q + ROW_W'(1);
              end
              CH_CR: cur_x_d = '0;
              CH_BS: begin
                state_d = ST_BSWR;
                if (cur_x_q != '0) begin
                  cur_x_d = cur_x_q - COL_W'(1);
                end else if (cur_y_q != '0) begin
                  cur_x_d = '1;
                  cur_y_d = cur_y_q - ROW_W'(1);
                end
              end
              CH_FF: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_BSWR: begin
        if (!disp_req) begin
          ram_we   = 1'b1;
          ram_addr = {cur_x_q, cur_y_q};
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_CLEAR;
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  assign ram_en = disp_req | ram_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      busy_q    <= busy_d;
    end
  end

  // The RAM read register is the disp_code register: it only loads on
  // display reads (writes never assert a read) and resets to 8'h00.
  text_ram #(
    .AW (AW),
    .DW (8)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (disp_code)
  );

  assign cursor_x = cur_x_q;
  assign cursor_y = cur_y_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_text_buf_ctrl.sv
module tb_text_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       disp_req;
  logic [7:0] disp_addr;
  logic [7:0] disp_code;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic [3:0] cursor_x;
  logic [3:0] cursor_y;
  logic       busy;

  text_buf_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_code (disp_code),
    .wr_valid  (wr_valid),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: screen contents indexed by col*16+row, cursor, and
  // the last code the display path should be showing.
  logic [7:0] mem [256];
  int         cx = 0;
  int         cy = 0;
  logic [7:0] last_code = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_accept(input logic [7:0] c);
    if (c >= 8'h20) begin
      mem[cx*16 + cy] = c;
      cx = (cx + 1) % 16;
      if (cx == 0) cy = (cy + 1) % 16;
    end else if (c == 8'h0A) begin
      cx = 0;
      cy = (cy + 1) % 16;
    end else if (c == 8'h0D) begin
      cx = 0;
    end else if (c == 8'h08) begin
      if (cx > 0) cx = cx - 1;
      else if (cy > 0) begin
        cx = 15;
        cy = cy - 1;
      end
    end
  endfunction

  // Writer transfer with random display traffic; backspace also runs BSWR.
  task automatic send_char(input logic [7:0] c);
    int n; bit done; bit req; int a; logic [7:0] exp;
    n = 0; done = 1'b0;
    wr_valid = 1'b1; wr_char = c;
    while (!done && n < 64) begin
      req = ($urandom_range(0, 2) == 0);
      a = $urandom_range(0, 255);
      disp_req = req; disp_addr = 8'(a);
      #1;
      n_cmp++;
      if (wr_ready !== ~req) begin
        n_err++; $display("FAIL wr_ready_idle: got %b exp %b", wr_ready, ~req);
      end
      exp = mem[a];
      tick(); n++;
      n_cmp++;
      if (req) begin
        if (disp_code !== exp) begin
          n_err++; $display("FAIL wr_disp_read[%0d]: got %h exp %h", a, disp_code, exp);
        end
        last_code = exp;
      end else begin
        if (disp_code !== last_code) begin
          n_err++; $display("FAIL wr_disp_hold: got %h exp %h", disp_code, last_code);
        end
        done = 1'b1;
        model_accept(c);
      end
    end
    wr_valid = 1'b0; disp_req = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL wr_timeout: char %h got no handshake exp handshake", c);
    end else if (cursor_x !== 4'(cx) || cursor_y !== 4'(cy)) begin
      n_err++; $display("FAIL cursor after %h: got (%0d,%0d) exp (%0d,%0d)", c, cursor_x, cursor_y, cx, cy);
    end
    if (done && c == 8'h08) begin
      n = 0; done = 1'b0;
      while (!done && n < 64) begin
        req = ($urandom_range(0, 1) == 0);
        a = $urandom_range(0, 255);
        disp_req = req; disp_addr = 8'(a);
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
          n_err++; $display("FAIL wr_ready_bswr: got %b exp 0", wr_ready);
        end
        exp = mem[a];
        tick(); n++;
        if (req) begin
          n_cmp++;
          if (disp_code !== exp) begin
            n_err++; $display("FAIL bswr_disp_read[%0d]: got %h exp %h", a, disp_code, exp);
          end
          last_code = exp;
        end else begin
          done = 1'b1;
          mem[cx*16 + cy] = 8'h20;
        end
      end
      disp_req = 1'b0;
      if (!done) begin
        n_cmp++; n_err++; $display("FAIL bswr_timeout: got stuck exp fill write");
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = 8'h00; wr_valid = 1'b0; wr_char = 8'h00;
    #1;
    tick(); tick();
    n_cmp++;
    if (disp_code !== 8'h00 || wr_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL reset_outputs: got code=%h rdy=%b busy=%b exp 00/0/1", disp_code, wr_ready, busy);
    end
    n_cmp++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
      n_err++; $display("FAIL reset_cursor: got (%0d,%0d) exp (0,0)", cursor_x, cursor_y);
    end
    rst_n = 1'b1;
    last_code = 8'h00;
  endtask

  // Clear after reset with no display traffic, then read back the whole screen.
  task automatic test_clear_after_reset();
    int n0;
    n0 = 0;
    disp_req = 1'b0;
    do begin
      tick(); n0++;
      if (n0 <= 256) mem[n0 - 1] = 8'h20;
    end while (busy === 1'b1 && n0 < 400);
    n_cmp++;
    if (n0 != 256) begin
      n_err++; $display("FAIL clear_len: got %0d exp 256", n0);
    end
    cx = 0; cy = 0;
    n_cmp++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
      n_err++; $display("FAIL clear_cursor: got (%0d,%0d) exp (0,0)", cursor_x, cursor_y);
    end
    for (int a = 0; a < 256; a++) begin
      disp_req = 1'b1; disp_addr = 8'(a);
      tick();
      n_cmp++;
      if (disp_code !== 8'h20) begin
        n_err++; $display("FAIL clear_read[%0d]: got %h exp 20", a, disp_code);
      end
    end
    last_code = 8'h20;
    disp_req = 1'b0;
  endtask

  task automatic test_text_lf();
    logic [7:0] s [5];
    int addrs [3];
    s[0] = 8'h41; s[1] = 8'h42; s[2] = 8'h0A; s[3] = 8'h43; s[4] = 8'h07;
    for (int i = 0; i < 5; i++) send_char(s[i]);
    n_cmp++;
    if (cursor_x !== 4'd1 || cursor_y !== 4'd1) begin
      n_err++; $display("FAIL text_cursor: got (%0d,%0d) exp (1,1)", cursor_x, cursor_y);
    end
    addrs[0] = 0; addrs[1] = 16; addrs[2] = 1;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = 8'(addrs[i]);
      tick();
      n_cmp++;
      if (disp_code !== mem[addrs[i]]) begin
        n_err++; $display("FAIL text_read[%0d]: got %h exp %h", addrs[i], disp_code, mem[addrs[i]]);
      end
      last_code = mem[addrs[i]];
    end
    disp_req = 1'b0;
  endtask

  // Form feed while display holds the port: clear must wait, then run 256 cycles.
  task automatic test_ff_stall();
    int n0; int a; logic [7:0] exp;
    send_char(8'h0C);
    disp_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, 255); disp_addr = 8'(a);
      #1;
      n_cmp++;
      if (wr_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL ff_stall: got rdy=%b busy=%b exp 0/1", wr_ready, busy);
      end
      exp = mem[a];
      tick();
      n_cmp++;
      if (disp_code !== exp) begin
        n_err++; $display("FAIL ff_stall_read[%0d]: got %h exp %h", a, disp_code, exp);
      end
      last_code = exp;
    end
    disp_req = 1'b0;
    n0 = 0;
    do begin
      #1;
      if (wr_ready !== 1'b0) begin
        n_cmp++; n_err++; $display("FAIL ff_wr_ready: got %b exp 0", wr_ready);
      end
      tick(); n0++;
    end while (busy === 1'b1 && n0 < 400);
    n_cmp++;
    if (n0 != 256) begin
      n_err++; $display("FAIL ff_clear_len: got %0d exp 256", n0);
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'h20;
    cx = 0; cy = 0;
    n_cmp++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
      n_err++; $display("FAIL ff_cursor: got (%0d,%0d) exp (0,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) send_char(8'(8'h30 + (i % 8'h50)));
    n_cmp++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
      n_err++; $display("FAIL wrap_cursor: got (%0d,%0d) exp (0,0)", cursor_x, cursor_y);
    end
    send_char(8'h5A);
    disp_req = 1'b1; disp_addr = 8'h00;
    tick();
    n_cmp++;
    if (disp_code !== 8'h5A) begin
      n_err++; $display("FAIL wrap_overwrite: got %h exp 5a", disp_code);
    end
    last_code = 8'h5A;
    disp_req = 1'b0;
  endtask

  task automatic test_backspace();
    logic [7:0] s [7];
    s[0] = 8'h0A; s[1] = 8'h0A; s[2] = 8'h08;
    s[3] = 8'h0D; s[4] = 8'h08; s[5] = 8'h0D; s[6] = 8'h08;
    for (int i = 0; i < 3; i++) send_char(s[i]);
    n_cmp++;
    if (cursor_x !== 4'd15 || cursor_y !== 4'd1) begin
      n_err++; $display("FAIL bs_cursor: got (%0d,%0d) exp (15,1)", cursor_x, cursor_y);
    end
    disp_req = 1'b1; disp_addr = 8'(15*16 + 1);
    tick();
    n_cmp++;
    if (disp_code !== 8'h20) begin
      n_err++; $display("FAIL bs_fill: got %h exp 20", disp_code);
    end
    last_code = 8'h20;
    disp_req = 1'b0;
    for (int i = 3; i < 7; i++) send_char(s[i]);
    n_cmp++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
      n_err++; $display("FAIL bs_origin: got (%0d,%0d) exp (0,0)", cursor_x, cursor_y);
    end
  endtask

  // Toggled clear, async reset mid-way, then a full toggled clear from 0.
  task automatic test_reset_mid_clear();
    int nzero; int ncyc; int a; bit req; logic [7:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (disp_code !== 8'h00 || busy !== 1'b1 || wr_ready !== 1'b0 ||
          cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
        n_err++; $display("FAIL async_reset[%0d]: got code=%h busy=%b rdy=%b cur=(%0d,%0d) exp 00/1/0/(0,0)",
                          pass, disp_code, busy, wr_ready, cursor_x, cursor_y);
      end
      tick();
      rst_n = 1'b1;
      last_code = 8'h00; cx = 0; cy = 0;
      nzero = 0; ncyc = 0;
      while (nzero < (pass == 0 ? 100 : 256) && ncyc < 1200) begin
        req = ($urandom_range(0, 1) == 0);
        a = $urandom_range(0, 255);
        disp_req = req; disp_addr = 8'(a);
        exp = mem[a];
        tick(); ncyc++;
        if (req) begin
          n_cmp++;
          if (disp_code !== exp) begin
            n_err++; $display("FAIL clr_read[%0d]: got %h exp %h", a, disp_code, exp);
          end
          last_code = exp;
        end else begin
          mem[nzero] = 8'h20;
          nzero++;
        end
        n_cmp++;
        if (busy !== (nzero < 256)) begin
          n_err++; $display("FAIL clr_busy: got %b exp %b after %0d fills", busy, nzero < 256, nzero);
        end
      end
      disp_req = 1'b0;
      n_cmp++;
      if (ncyc >= 1200) begin
        n_err++; $display("FAIL clr_timeout: got %0d fills exp completion", nzero);
      end
      #2;
    end
    n_cmp++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0 || wr_ready !== 1'b1) begin
      n_err++; $display("FAIL clr_end: got cur=(%0d,%0d) rdy=%b exp (0,0)/1", cursor_x, cursor_y, wr_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_after_reset();
    test_text_lf();
    test_ff_stall();
    test_wrap();
    test_backspace();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_buf_ctrl.md
# text_buf_ctrl

Controller for the on-screen text buffer that feeds the character renderer. It owns a single-port character RAM of 16 columns × 16 rows. The RAM is shared between two requesters: the display read path and a character-stream writer.
- Display read path: char_xy-style addresses from the renderer, with fixed one-cycle latency.
- Writer: valid/ready handshake, with cursor handling, control characters and a clear-screen sequencer.

The controller sits between the renderer's char_xy output and the font ROM's char-code input.

## Interface
Parameters:
- FILL_CHAR, 8'h20, code written by clear and backspace
- COL_W, 4, column index width (16 columns)
- ROW_W, 4, row index width (16 rows)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- disp_req  in  1  display read request this cycle (renderer inside text frame)
- disp_addr  in  COL_W+ROW_W  {col, row}, same packing as renderer char_xy
- disp_code  out  8  character code read for disp_addr, to font ROM address high bits
- wr_valid  in  1  writer has a character
- wr_char  in  8  character from writer
- wr_ready  out  1  controller accepts wr_char this cycle
- cursor_x  out  COL_W  current write column
- cursor_y  out  ROW_W  current write row
- busy  out  1  clear sequence in progress

## Operation
- RAM: 256×8, one port, synchronous read (1 cycle), write on the port cycle.
- Arbitration: the display has absolute priority.
  - disp_req=1: the port reads disp_addr, and no write occurs that cycle.
  - Writer and clear sequencer use the port only on disp_req=0 cycles.
- FSM states:
  - CLEAR:
    - Writes FILL_CHAR at clr_cnt on each disp_req=0 cycle, then increments clr_cnt.
    - Stalls while disp_req=1.
    - After the write at 255, goes to IDLE with clr_cnt=0 and cursor=(0,0).
  - IDLE:
    - wr_ready = !disp_req. A transfer occurs when wr_valid && wr_ready.
    - Printable (>= 8'h20): write wr_char at {cursor_x, cursor_y} the same cycle, then advance the cursor.
    - 8'h0A (LF): cursor_x=0, cursor_y+1. No RAM access.
    - 8'h0D (CR): cursor_x=0. No RAM access.
    - 8'h08 (BS): move the cursor back one cell, go to BSWR. At (0,0) the cursor stays at (0,0).
    - 8'h0C (FF): go to CLEAR.
    - Other codes < 8'h20: accepted and ignored.
  - BSWR: writes FILL_CHAR at the cursor on the first disp_req=0 cycle, then goes to IDLE. wr_ready=0.
- Cursor advance:
  - Column 15 → 0 with row+1.
  - Row 15 → 0 (wrap to top, no scroll).
  - So (15,15) advances to (0,0).
- Backspace from (0,r>0) goes to (15,r-1).
- Reset:
  - Enters CLEAR with clr_cnt=0, so the screen is blanked without external action.
  - Reset mid-clear or mid-BSWR restarts the clear from 0.

## Timing
- Reset values:
  - disp_code=8'h00, wr_ready=0, busy=1, cursor_x=0, cursor_y=0.
  - Internal: state=CLEAR, clr_cnt=0.
- Display latency: disp_code is valid exactly 1 cycle after a disp_req=1 cycle, regardless of writer or clear activity.
  - disp_code updates only on cycles following disp_req=1 and holds otherwise.
- busy=1 in CLEAR only. Clear takes 256 disp_req=0 cycles, so 256 cycles minimum.
- wr_ready:
  - Combinational from state and disp_req.
  - 0 in CLEAR and BSWR, and in IDLE whenever disp_req=1.
  - The writer must hold wr_valid/wr_char until the handshake.
- Cursor outputs update on the clock edge that completes the transfer.
  - For BS, the cursor updates on the accept edge, before the BSWR write.
- A printable write and a same-cycle disp_req cannot coincide: ready is low then.

## Structure
- Package text_buf_pkg:
  - FSM state enum (CLEAR, IDLE, BSWR).
  - Control codes CH_LF, CH_CR, CH_BS, CH_FF.
  - Geometry constants TXT_COLS, TXT_ROWS.
- Sub-module text_ram: 256×8 single-port synchronous RAM, parameterised by address width; no reset on contents.
- text_buf_ctrl holds the FSM, cursor counters, clr_cnt, the port mux and the disp_code register.

## Test plan
- Reset release, disp_req=0: busy high for 256 cycles, then low; reading all 256 addresses returns 8'h20; cursor=(0,0).
- disp_req toggled 1/0 during clear: clear completes after exactly 256 disp_req=0 cycles; every display read returns a code 1 cycle later, with no write collision.
- Write "AB" then LF then "C": RAM {0,0}=8'h41, {1,0}=8'h42, {0,1}=8'h43; cursor=(1,1).
- 256 printable writes 8'h30..: cursor wraps (15,15)→(0,0), and the 257th write overwrites {0,0}.
- Cursor (0,2), send BS: cursor=(15,1), {15,1}=8'h20 after BSWR; at (0,0), BS keeps (0,0).
- Send 8'h0C with disp_req held high 10 cycles, then low: wr_ready stays 0 throughout; busy rises, clear runs, and cursor returns to (0,0).
- Assert rst_n low mid-clear: outputs take reset values immediately (async), and the clear restarts from address 0.
